multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM for the non-pipelined 16-bit core. Sequences fetch, decode (operand/imm

---
 rtl/multicycle_ctrl_pkg.sv | 50 +++++
 rtl/multicycle_ctrl_if.sv | 35 +++
 rtl/multicycle_ctrl_opdec.sv | 41 ++++
 rtl/multicycle_ctrl.sv | 144 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle sequencer: opcodes, ALU/PC-mux codes, FSM states.
// The TRAP state exists only when ILLEGAL_OP_TRAP_EN is defined.
package multicycle_ctrl_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_OP_ADD = 3'd0;
  localparam logic [2:0] ALU_OP_SUB = 3'd1;
  localparam logic [2:0] ALU_OP_AND = 3'd2;
  localparam logic [2:0] ALU_OP_OR  = 3'd3;

  localparam logic [1:0] PC_SRC_INC  = 2'd0;
  localparam logic [1:0] PC_SRC_REL  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP  = 2'd2;
  localparam logic [1:0] PC_SRC_TRAP = 2'd3;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
`ifdef ILLEGAL_OP_TRAP_EN
    , ST_TRAP = 3'd7
`endif
  } state_e;

  typedef struct packed {
    logic rtype;
    logic imm;
    logic load;
    logic store;
    logic branch;
    logic jump;
    logic halt;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the sequencer (master) and the datapath (slave).
// trap_vec carries the PC value the datapath loads when pc_src selects the trap vector.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       ir_opcode;
  logic             zero_flag;
  logic             mem_ack;
  logic             mem_req;
  logic             mem_we;
  logic             mem_addr_sel;
  logic             ir_we;
  logic             pc_we;
  logic [1:0]       pc_src;
  logic [2:0]       alu_op;
  logic             alu_src_imm;
  logic             rf_we;
  logic             rf_wsel;
  logic             halted;
  logic             trap;
  logic [CNT_W-1:0] retire_cnt;
  logic [15:0]      trap_vec;

  modport master (
    input  ir_opcode, zero_flag, mem_ack,
    output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_op,
           alu_src_imm, rf_we, rf_wsel, halted, trap, retire_cnt, trap_vec
  );

  modport slave (
    output ir_opcode, zero_flag, mem_ack,
    input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_op,
           alu_src_imm, rf_we, rf_wsel, halted, trap, retire_cnt, trap_vec
  );
endinterface

// File: rtl/multicycle_ctrl_opdec.sv
// Combinational opcode classifier: maps IR[15:12] to instruction-class flags and the ALU op.
module ctrl_opcode_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [3:0] opcode_i,
  output op_class_t  cls_o,
  output logic [2:0] alu_op_o
);

  // Memory ops and ADDI compute addresses/sums with ADD; BEQ compares via SUB.
  always_comb begin
    cls_o    = '0;
    alu_op_o = ALU_OP_ADD;
    case (opcode_i)
      OP_ADD:  cls_o.rtype = 1'b1;
      OP_SUB: begin
        cls_o.rtype = 1'b1;
        alu_op_o    = ALU_OP_SUB;
      end
      OP_AND: begin
        cls_o.rtype = 1'b1;
        alu_op_o    = ALU_OP_AND;
      end
      OP_OR: begin
        cls_o.rtype = 1'b1;
        alu_op_o    = ALU_OP_OR;
      end
      OP_ADDI: cls_o.imm   = 1'b1;
      OP_LW:   cls_o.load  = 1'b1;
      OP_SW:   cls_o.store = 1'b1;
      OP_BEQ: begin
        cls_o.branch = 1'b1;
        alu_op_o     = ALU_OP_SUB;
      end
      OP_JMP:  cls_o.jump = 1'b1;
      OP_HALT: cls_o.halt = 1'b1;
      default: cls_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the 16-bit core: fetch/decode/exec/mem/wb FSM plus retire counter.
// Define ILLEGAL_OP_TRAP_EN to trap illegal opcodes to TRAP_VEC; otherwise they retire as NOPs.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter logic [15:0] TRAP_VEC = 16'h00F0,
  parameter int          CNT_W    = 16
)(
  input  logic                clk,
  input  logic                rst_n,
  multicycle_ctrl_if.master   bus_if
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic             retire_inc;
  op_class_t        cls;
  logic [2:0]       dec_alu_op;

  ctrl_opcode_decode u_opdec (
    .opcode_i (bus_if.ir_opcode),
    .cls_o    (cls),
    .alu_op_o (dec_alu_op)
  );

  assign retire_cnt_d      = retire_inc ? retire_cnt_q + CNT_W'(1) : retire_cnt_q;
  assign bus_if.retire_cnt = retire_cnt_q;
  assign bus_if.trap_vec   = TRAP_VEC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RST;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // All strobes are pure functions of state and opcode, so reset forces them low at once.
  always_comb begin
    state_d             = state_q;
    retire_inc          = 1'b0;
    bus_if.mem_req      = 1'b0;
    bus_if.mem_we       = 1'b0;
    bus_if.mem_addr_sel = 1'b0;
    bus_if.ir_we        = 1'b0;
    bus_if.pc_we        = 1'b0;
    bus_if.pc_src       = PC_SRC_INC;
    bus_if.alu_op       = ALU_OP_ADD;
    bus_if.alu_src_imm  = 1'b0;
    bus_if.rf_we        = 1'b0;
    bus_if.rf_wsel      = 1'b0;
    bus_if.halted       = 1'b0;
    bus_if.trap         = 1'b0;

    case (state_q)
      ST_RST: state_d = ST_FETCH;

      ST_FETCH: begin
        bus_if.mem_req = 1'b1;
        if (bus_if.mem_ack) begin
          bus_if.ir_we  = 1'b1;
          bus_if.pc_we  = 1'b1;
          bus_if.pc_src = PC_SRC_INC;
          state_d       = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (cls.halt) begin
          state_d    = ST_HALT;
          retire_inc = 1'b1;
        end else if (cls.illegal) begin
`ifdef ILLEGAL_OP_TRAP_EN
          state_d    = ST_TRAP;
`else
          state_d    = ST_FETCH;
          retire_inc = 1'b1;
`endif
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        bus_if.alu_op      = dec_alu_op;
        bus_if.alu_src_imm = cls.imm | cls.load | cls.store;
        if (cls.branch) begin
          bus_if.pc_we  = bus_if.zero_flag;
          bus_if.pc_src = PC_SRC_REL;
          state_d       = ST_FETCH;
          retire_inc    = 1'b1;
        end else if (cls.jump) begin
          bus_if.pc_we  = 1'b1;
          bus_if.pc_src = PC_SRC_JMP;
          state_d       = ST_FETCH;
          retire_inc    = 1'b1;
        end else if (cls.load || cls.store) begin
          state_d = ST_MEM;
        end else if (cls.rtype || cls.imm) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_MEM: begin
        bus_if.mem_req      = 1'b1;
        bus_if.mem_addr_sel = 1'b1;
        bus_if.mem_we       = cls.store;
        if (bus_if.mem_ack) begin
          if (cls.store) begin
            state_d    = ST_FETCH;
            retire_inc = 1'b1;
          end else begin
            state_d = ST_WB;
          end
        end
      end

      ST_WB: begin
        bus_if.rf_we   = 1'b1;
        bus_if.rf_wsel = cls.load;
        state_d        = ST_FETCH;
        retire_inc     = 1'b1;
      end

      ST_HALT: bus_if.halted = 1'b1;

`ifdef ILLEGAL_OP_TRAP_EN
      ST_TRAP: begin
        bus_if.trap   = 1'b1;
        bus_if.pc_we  = 1'b1;
        bus_if.pc_src = PC_SRC_TRAP;
        state_d       = ST_FETCH;
      end
`endif

      default: state_d = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed table-driven bench for multicycle_ctrl plus hand-written multi-cycle corner sequences.
// Expected values follow ILLEGAL_OP_TRAP_EN when it is defined for the build.
module tb_multicycle_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;

  multicycle_ctrl_if #(.CNT_W(16)) bus ();

  multicycle_ctrl #(.TRAP_VEC(16'h00F0), .CNT_W(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic       zero;
    int         lat;
    logic [2:0] alu;
    logic       imm;
    logic       rfwe;
    logic       wsel;
    logic       memwe;
    logic       pcwe;
    logic [1:0] pcsrc;
    logic       trap;
    int         inc;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [14:0] allOut();
    return {bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.ir_we, bus.pc_we,
            bus.pc_src, bus.alu_op, bus.alu_src_imm, bus.rf_we, bus.rf_wsel,
            bus.halted, bus.trap};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Entered at a negedge while the DUT sits in FETCH with mem_ack=1; leaves at the next FETCH.
  task automatic applyStimulus(input vec_t v);
    logic [15:0] r0;
    logic [15:0] d;
    int          lat;
    logic [2:0]  alu_or;
    logic        imm_or, rfwe_or, wsel_or, memwe_or, pcwe_or, trap_or;
    logic [1:0]  pcsrc_or;
    bus.ir_opcode = v.op;
    bus.zero_flag = v.zero;
    #1;
    checkOutput({v.name, ".fetch"}, 32'({bus.mem_req, bus.mem_addr_sel, bus.ir_we, bus.pc_we, bus.pc_src}),
                32'b101100);
    r0 = bus.retire_cnt;
    lat = -1;
    alu_or = '0; pcsrc_or = '0;
    {imm_or, rfwe_or, wsel_or, memwe_or, pcwe_or, trap_or} = '0;
    for (int c = 2; c <= 12; c++) begin
      @(negedge clk);
      if (bus.ir_we) begin
        lat = c - 1;
        break;
      end
      alu_or   |= bus.alu_op;
      imm_or   |= bus.alu_src_imm;
      rfwe_or  |= bus.rf_we;
      wsel_or  |= bus.rf_we & bus.rf_wsel;
      memwe_or |= bus.mem_we;
      pcwe_or  |= bus.pc_we;
      pcsrc_or |= bus.pc_src;
      trap_or  |= bus.trap;
    end
    d = bus.retire_cnt - r0;
    checkOutput({v.name, ".latency"}, 32'(lat), 32'(v.lat));
    checkOutput({v.name, ".alu_op"}, 32'(alu_or), 32'(v.alu));
    checkOutput({v.name, ".alu_src_imm"}, 32'(imm_or), 32'(v.imm));
    checkOutput({v.name, ".rf_we"}, 32'(rfwe_or), 32'(v.rfwe));
    checkOutput({v.name, ".rf_wsel"}, 32'(wsel_or), 32'(v.wsel));
    checkOutput({v.name, ".mem_we"}, 32'(memwe_or), 32'(v.memwe));
    checkOutput({v.name, ".pc_we"}, 32'(pcwe_or), 32'(v.pcwe));
    checkOutput({v.name, ".pc_src"}, 32'(pcsrc_or), 32'(v.pcsrc));
    checkOutput({v.name, ".trap"}, 32'(trap_or), 32'(v.trap));
    checkOutput({v.name, ".retire"}, 32'(d), 32'(v.inc));
  endtask

  // Holds reset two cycles, releases it, and lands at a negedge of the first FETCH cycle.
  task automatic doReset();
    rst_n       = 1'b0;
    bus.mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] r0;
    int          lat, memcnt, rfwe_c;
    logic        wsel;
    logic        bad;
    checks = 0;
    passed = 0;

    //              name    op    z  lat alu imm rf ws mw pw src tr inc
    vecs[0]  = '{"ADD",  4'h0, 0, 4, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    vecs[1]  = '{"SUB",  4'h1, 0, 4, 1, 0, 1, 0, 0, 0, 0, 0, 1};
    vecs[2]  = '{"AND",  4'h2, 0, 4, 2, 0, 1, 0, 0, 0, 0, 0, 1};
    vecs[3]  = '{"OR",   4'h3, 0, 4, 3, 0, 1, 0, 0, 0, 0, 0, 1};
    vecs[4]  = '{"ADDI", 4'h4, 0, 4, 0, 1, 1, 0, 0, 0, 0, 0, 1};
    vecs[5]  = '{"LW",   4'h5, 0, 5, 0, 1, 1, 1, 0, 0, 0, 0, 1};
    vecs[6]  = '{"SW",   4'h6, 0, 4, 0, 1, 0, 0, 1, 0, 0, 0, 1};
    vecs[7]  = '{"BEQ1", 4'h7, 1, 3, 1, 0, 0, 0, 0, 1, 1, 0, 1};
    vecs[8]  = '{"BEQ0", 4'h7, 0, 3, 1, 0, 0, 0, 0, 0, 1, 0, 1};
    vecs[9]  = '{"JMP",  4'h8, 0, 3, 0, 0, 0, 0, 0, 1, 2, 0, 1};
`ifdef ILLEGAL_OP_TRAP_EN
    vecs[10] = '{"ILL",  4'hA, 0, 3, 0, 0, 0, 0, 0, 1, 3, 1, 0};
`else
    vecs[10] = '{"ILL",  4'hA, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1};
`endif

    rst_n         = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.ir_opcode = 4'h0;
    bus.zero_flag = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.outputs", 32'(allOut()), 32'h0);
    checkOutput("reset.retire", 32'(bus.retire_cnt), 32'h0);
    checkOutput("trap_vec", 32'(bus.trap_vec), 32'h00F0);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_state.outputs", 32'(allOut()), 32'h0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("fetch_wait1", 32'(allOut()), 32'h4000);
    @(negedge clk);
    checkOutput("fetch_wait2", 32'(allOut()), 32'h4000);
    bus.mem_ack = 1'b1;

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

    // LW with three wait cycles in MEM: 8 cycles total, MEM strobes held 4 cycles.
    $display("[TB] LW with delayed memory ack");
    bus.ir_opcode = 4'h5;
    bus.mem_ack   = 1'b1;
    #1;
    checkOutput("lwwait.fetch", 32'(bus.ir_we), 32'h1);
    r0 = bus.retire_cnt;
    lat = -1; memcnt = 0; rfwe_c = 0; wsel = 1'b0;
    for (int c = 2; c <= 14; c++) begin
      @(negedge clk);
      bus.mem_ack = (c >= 7);
      #1;
      if (bus.ir_we) begin
        lat = c - 1;
        break;
      end
      if (bus.mem_req && bus.mem_addr_sel) memcnt++;
      if (bus.rf_we) begin
        rfwe_c = c;
        wsel   = bus.rf_wsel;
      end
    end
    checkOutput("lwwait.latency", 32'(lat), 32'd8);
    checkOutput("lwwait.mem_cycles", 32'(memcnt), 32'd4);
    checkOutput("lwwait.rf_we_cycle", 32'(rfwe_c), 32'd8);
    checkOutput("lwwait.rf_wsel", 32'(wsel), 32'h1);
    checkOutput("lwwait.retire", 32'(16'(bus.retire_cnt - r0)), 32'h1);

    // Counter wrap: preload all-ones while FETCH stalls, then retire one ADD.
    $display("[TB] retire counter wrap");
    bus.mem_ack = 1'b0;
    force dut.retire_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.retire_cnt_q;
    checkOutput("wrap.preload", 32'(bus.retire_cnt), 32'hFFFF);
    bus.mem_ack = 1'b1;
    applyStimulus(vecs[0]);
    checkOutput("wrap.value", 32'(bus.retire_cnt), 32'h0);

    // HALT absorbs and ignores mem_ack activity.
    $display("[TB] HALT");
    bus.ir_opcode = 4'hF;
    #1;
    r0 = bus.retire_cnt;
    @(negedge clk);
    @(negedge clk);
    checkOutput("halt.enter", 32'(allOut()), 32'h0002);
    bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      bus.mem_ack = ~bus.mem_ack;
      @(negedge clk);
      if (allOut() !== 15'h0002) bad = 1'b1;
    end
    checkOutput("halt.absorbing", 32'(bad), 32'h0);
    checkOutput("halt.retire", 32'(16'(bus.retire_cnt - r0)), 32'h1);

    // Asynchronous reset in the middle of a stalled SW memory access.
    $display("[TB] async reset mid-MEM");
    doReset();
    bus.ir_opcode = 4'h6;
    bus.mem_ack   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    @(negedge clk);
    checkOutput("midmem.strobes", 32'(allOut()), 32'h7000);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midmem.reset_outputs", 32'(allOut()), 32'h0);
    checkOutput("midmem.reset_retire", 32'(bus.retire_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
